// File: rtl/dr_scan_drv.sv
// Single-rail to dual-rail scan driver for a return-to-spacer scan chain, plus capture tokens.
// Define DR_SCAN_PARITY_EN to add the parity output and the exp_parity check.
module dr_scan_drv #(
   parameter int CHAIN_LEN = 16,
   parameter int CNT_W     = 5
) (
   input  logic             C,
   input  logic             RN,
   input  logic             start,
   input  logic             mode,
   input  logic             sin,
   input  logic             sin_valid,
   output logic             sin_ready,
   output logic             SE_1,
   output logic             SE_0,
   output logic             SD_1,
   output logic             SD_0,
   output logic             SP,
   input  logic             SQ_1,
   input  logic             SQ_0,
   output logic             sout,
   output logic             sout_valid,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] cnt,
`ifdef DR_SCAN_PARITY_EN
   output logic             parity,
   input  logic             exp_parity,
`endif
   output logic [2:0]       dbg_state_o
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SPACER = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_CAPT   = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   localparam logic [CNT_W-1:0] LEN_C = CNT_W'(CHAIN_LEN);

   logic [2:0]       state_q, state_d;
   logic             mode_q, mode_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [1:0]       se_q, se_d;
   logic [1:0]       sd_q, sd_d;
   logic             sp_q, sp_d;
   logic             sout_q, sout_d;
   logic             sout_valid_q, sout_valid_d;
   logic             done_q, done_d;
`ifdef DR_SCAN_PARITY_EN
   logic             parity_q, parity_d;
`endif

   logic sq_legal;
   logic sq_active;
   logic cnt_full;

   assign sq_legal  = SQ_1 ^ SQ_0;
   assign sq_active = SQ_1 | SQ_0;
   assign cnt_full  = (cnt_q >= LEN_C);

   // Handshake: a bit transfers on a rising edge where sin_valid and sin_ready are both high;
   // sin_ready only rises in SPACER while a shift still needs bits and mirrors sin_valid there.
   assign sin_ready = (state_q == ST_SPACER) && !mode_q && !cnt_full && sin_valid;

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
      sout_d       = sout_q;
      sout_valid_d = 1'b0;
      done_d       = 1'b0;
      se_d         = 2'b00;
      sd_d         = 2'b00;
      sp_d         = 1'b1;
`ifdef DR_SCAN_PARITY_EN
      parity_d     = parity_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SPACER;
               mode_d  = mode;
               cnt_d   = '0;
               err_d   = 1'b0;
`ifdef DR_SCAN_PARITY_EN
               parity_d = 1'b0;
`endif
            end
         end
         ST_SPACER: begin
            if (sq_active) err_d = 1'b1;
            if (!mode_q) begin
               if (cnt_full) begin
                  state_d = ST_DONE;
               end else if (sin_ready) begin
                  state_d = ST_DATA;
                  sd_d    = {sin, ~sin};
                  se_d    = 2'b10;
                  sp_d    = 1'b0;
               end
            end else if (cnt_q == '0) begin
               // Capture token: SE carries logic 0, SD stays at spacer.
               state_d = ST_CAPT;
               se_d    = 2'b01;
               sp_d    = 1'b0;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DATA, ST_CAPT: begin
            if (sq_legal) begin
               sout_d       = SQ_1;
               sout_valid_d = 1'b1;
`ifdef DR_SCAN_PARITY_EN
               parity_d     = parity_q ^ SQ_1;
`endif
            end else begin
               err_d = 1'b1;
            end
            if (state_q == ST_CAPT) begin
               cnt_d = CNT_W'(1);
            end else if (!cnt_full) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            state_d = ST_SPACER;
         end
         ST_DONE: begin
            if (sq_active) err_d = 1'b1;
`ifdef DR_SCAN_PARITY_EN
            if (exp_parity != parity_q) err_d = 1'b1;
`endif
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge C or negedge RN) begin
      if (!RN) begin
         state_q      <= ST_IDLE;
         mode_q       <= 1'b0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
         se_q         <= 2'b00;
         sd_q         <= 2'b00;
         sp_q         <= 1'b1;
         sout_q       <= 1'b0;
         sout_valid_q <= 1'b0;
         done_q       <= 1'b0;
`ifdef DR_SCAN_PARITY_EN
         parity_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
         se_q         <= se_d;
         sd_q         <= sd_d;
         sp_q         <= sp_d;
         sout_q       <= sout_d;
         sout_valid_q <= sout_valid_d;
         done_q       <= done_d;
`ifdef DR_SCAN_PARITY_EN
         parity_q     <= parity_d;
`endif
      end
   end

   assign {SE_1, SE_0} = se_q;
   assign {SD_1, SD_0} = sd_q;
   assign SP           = sp_q;
   assign sout         = sout_q;
   assign sout_valid   = sout_valid_q;
   assign done         = done_q;
   assign err          = err_q;
   assign cnt          = cnt_q;
   assign busy         = (state_q != ST_IDLE);
   assign dbg_state_o  = state_q;
`ifdef DR_SCAN_PARITY_EN
   assign parity       = parity_q;
`endif

endmodule

// File: doc/dr_scan_drv.md
Name: dr_scan_drv

Overview:
- Upstream driver for a chain of dual-rail multiplexed-scan flip-flops.
- Converts a single-rail serial scan stream, taken over a valid/ready handshake, into the dual-rail SD and SE codes the chain expects, using return-to-spacer phasing driven on SP.
- Samples the chain's dual-rail scan-out, returns it single-rail, and flags illegal codes.
- Also issues single functional-capture tokens.

Parameters:
- CHAIN_LEN, 16: number of flops in the scan chain (>=1).
- CNT_W, 5: counter width; must satisfy 2**CNT_W > CHAIN_LEN.

Ports:
- C  in  1  clock, rising edge.
- RN  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request; accepted only in IDLE.
- mode  in  1  sampled with start: 0 = shift CHAIN_LEN bits, 1 = single capture token.
- sin  in  1  serial scan-in bit.
- sin_valid  in  1  sin is valid.
- sin_ready  out  1  bit accepted this cycle (combinational).
- SE_1, SE_0  out  1 each  dual-rail scan enable to chain (registered).
- SD_1, SD_0  out  1 each  dual-rail scan data to chain head (registered).
- SP  out  1  spacer phase: 1 = spacer cycle, 0 = data cycle (registered).
- SQ_1, SQ_0  in  1 each  dual-rail scan-out from chain tail.
- sout  out  1  recovered scan-out bit.
- sout_valid  out  1  one-cycle strobe for sout.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle strobe at operation end.
- err  out  1  sticky illegal-code flag; cleared on accepted start.
- cnt  out  CNT_W  data tokens issued in the current operation.

Behaviour:
- Reset (RN=0, async):
  - State IDLE; cnt=0; err=0.
  - SE_1=SE_0=SD_1=SD_0=0 (all-zero spacer); SP=1.
  - sout=0, sout_valid=0, done=0, busy=0.
- Dual-rail encoding:
  - Logic 1 = (_1,_0) = (1,0); logic 0 = (0,1); spacer = (0,0); (1,1) is illegal.
  - Every data cycle is followed by at least one spacer cycle.
- States: IDLE, SPACER, DATA, CAPT, DONE.
- IDLE:
  - Outputs hold spacer.
  - start=1 moves to SPACER: clears err, cnt=0, latches mode.
- SPACER (SP=1, SE/SD rails 0):
  - mode 0, cnt<CHAIN_LEN: sin_ready = sin_valid. On a handshake, register SD = code(sin), SE = code(1), SP=0, go to DATA.
  - No sin_valid: stay in SPACER indefinitely (stall). Spacer is held; no timeout.
  - mode 0, cnt==CHAIN_LEN: go to DONE.
  - mode 1, cnt==0: go to CAPT with SE = code(0), SD = spacer, SP=0.
  - mode 1, cnt==1: go to DONE.
- DATA (one cycle):
  - Sample SQ. Valid code: sout = SQ_1, sout_valid=1. Otherwise err=1, no strobe.
  - cnt increments, saturating at CHAIN_LEN. Return to SPACER, driving spacer.
- CAPT (one cycle):
  - Same SQ check; sout/sout_valid as in DATA.
  - cnt=1; go to SPACER.
- DONE: done=1 for one cycle; go to IDLE. busy falls on the same edge.
- Spacer checks: in SPACER or DONE, SQ != (0,0) sets err. SQ=(1,1) in any non-IDLE state sets err.
- sin_ready is 0 outside SPACER.
- Latency:
  - Handshake edge to data on SD: 1 cycle.
  - Data-phase SQ sample to sout_valid: 1 cycle.
  - Minimum full shift: 2*CHAIN_LEN+2 cycles from start to done.
- Boundary rules:
  - start while busy: ignored.
  - start and reset asserted together: reset wins.
  - Reset mid-operation: immediate return to spacer/IDLE; partial shift is discarded.
  - sin_valid with mode 1: never handshaked.

Optional Feature:
- Macro: DR_SCAN_PARITY_EN.
- Defined:
  - Adds output parity (1 bit): running XOR of every strobed sout in the current operation.
  - Cleared on accepted start; stable from the done strobe until the next start; reset value 0.
  - Also adds input exp_parity (1 bit), sampled in DONE; a mismatch sets err in the same edge as done.
- Undefined: neither port exists; err ignores parity.

Test Plan:
- Reset release, then idle 5 cycles -> SP=1, all SE/SD rails 0, busy=0, err=0, sin_ready=0.
- CHAIN_LEN=4, mode 0, sin=1,0,1,1 always valid, SQ model = 4-deep dual-rail shift register preloaded 0,1,1,0 -> SD sequence (1,0),(0,1),(1,0),(1,0) alternating with spacers; sout=0,1,1,0; done at cycle 10 after start; cnt=4; err=0.
- Same shift with sin_valid deasserted 3 cycles after the second bit -> SPACER held 3 extra cycles with rails 0; no extra sout_valid; done delayed by 3 cycles.
- mode 1 -> exactly one data cycle with SE=(0,1), SD=(0,0), SP=0; SQ=(1,0) gives sout=1; done 4 cycles after start.
- Force SQ=(1,1) during a DATA cycle; separately force SQ=(1,0) during a SPACER cycle -> err=1 each time, sticky until the next start; no sout_valid for the illegal data cycle.
- Assert RN=0 mid-shift at cnt=2 -> asynchronous return to SP=1, rails 0, cnt=0, busy=0. With DR_SCAN_PARITY_EN: sout 1,1,0,1 -> parity=1; exp_parity=0 -> err=1 with done.
